// File: rtl/mtm_delay_pipe_if.sv
// Handshake bundle for mtm_delay_pipe: upstream push side, downstream pop side,
// corner select and status outputs.
interface mtm_delay_pipe_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [7:0]       lat_active;
   logic             busy;

   modport master (
      output sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, lat_active, busy
   );

   modport slave (
      input  sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, lat_active, busy
   );
endinterface

// File: rtl/mtm_delay_pipe.sv
// Selectable-latency FIFO: each item matures lat_active cycles after its push and
// leaves in order; the latency corner is only resampled while the pipe is empty.
module mtm_delay_pipe #(
   parameter int WIDTH   = 8,
   parameter int MIN_DLY = 1,
   parameter int TYP_DLY = 2,
   parameter int MAX_DLY = 3,
   parameter int DEPTH   = 4
) (
   input logic            clk,
   input logic            rst,
   mtm_delay_pipe_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   if (!((MIN_DLY >= 1) && (MIN_DLY <= TYP_DLY) && (TYP_DLY <= MAX_DLY) &&
         (MAX_DLY <= 255) && (DEPTH >= 2) && (DEPTH <= 64) &&
         ((DEPTH & (DEPTH - 1)) == 0))) begin : g_param_err
      $error("mtm_delay_pipe: illegal parameters MIN=%0d TYP=%0d MAX=%0d DEPTH=%0d",
             MIN_DLY, TYP_DLY, MAX_DLY, DEPTH);
   end

   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]       lat_q, lat_d;
   logic [7:0]       cd_q [DEPTH];
   logic [7:0]       cd_d [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];

   logic [7:0] corner;
   logic [7:0] lat_eff;
   logic       empty;
   logic       push;
   logic       pop;
   logic       out_valid;

   always_comb begin
      case (bus.sel)
         2'd0:    corner = 8'(MIN_DLY);
         2'd2:    corner = 8'(MAX_DLY);
         default: corner = 8'(TYP_DLY);
      endcase
   end

   assign empty     = (count_q == '0);
   assign out_valid = !empty && (cd_q[rd_ptr_q] == 8'd0);
   assign push      = bus.in_valid && bus.in_ready;
   assign pop       = out_valid && bus.out_ready;

   // An empty pipe tracks sel every edge, so a push into it uses this edge's corner.
   assign lat_eff = empty ? corner : lat_q;
   assign lat_d   = lat_eff;

   always_comb begin
      logic [AW-1:0] offset;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cd_d[i] = cd_q[i];
         offset  = AW'(i) - rd_ptr_q;
         if (({1'b0, offset} < count_q) && (cd_q[i] != 8'd0)) begin
            cd_d[i] = cd_q[i] - 8'd1;
         end
      end
      if (push) begin
         cd_d[wr_ptr_q] = lat_eff - 8'd1;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lat_q    <= 8'(TYP_DLY);
         for (int unsigned i = 0; i < DEPTH; i++) begin
            cd_q[i] <= '0;
         end
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         lat_q    <= lat_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            cd_q[i] <= cd_d[i];
         end
      end
   end

   // Payload storage needs no reset: occupancy is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= bus.in_data;
      end
   end

   assign bus.in_ready   = (count_q != CW'(DEPTH));
   assign bus.out_valid  = out_valid;
   assign bus.out_data   = data_q[rd_ptr_q];
   assign bus.lat_active = lat_q;
   assign bus.busy       = !empty;
endmodule

// File: tb/tb_mtm_delay_pipe.sv
// Directed bench for mtm_delay_pipe with default parameters; expected values are
// hand-derived constants checked by immediate assertions.
module tb_mtm_delay_pipe;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mtm_delay_pipe_if #(.WIDTH(8)) bus ();

   mtm_delay_pipe #(
      .WIDTH(8), .MIN_DLY(1), .TYP_DLY(2), .MAX_DLY(3), .DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst            = 1'b1;
      bus.sel        = 2'd0;
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      bus.out_ready  = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rst_lat", 32'(bus.lat_active), 32'h2);
      rst = 1'b0;

      // min corner, single item visible the cycle after its push
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hA5;
      tick();
      bus.in_valid  = 1'b0;
      chk("min_valid", 32'(bus.out_valid), 32'h1);
      chk("min_data", 32'(bus.out_data), 32'hA5);
      chk("min_lat", 32'(bus.lat_active), 32'h1);
      tick();
      chk("min_valid_once", 32'(bus.out_valid), 32'h0);
      chk("min_busy_after", 32'(bus.busy), 32'h0);

      // max corner, three back-to-back items
      bus.sel      = 2'd2;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      tick();
      chk("max_lat0", 32'(bus.lat_active), 32'h3);
      chk("max_v0", 32'(bus.out_valid), 32'h0);
      bus.in_data = 8'h22;
      tick();
      chk("max_v1", 32'(bus.out_valid), 32'h0);
      bus.in_data = 8'h33;
      tick();
      bus.in_valid = 1'b0;
      chk("max_v2", 32'(bus.out_valid), 32'h1);
      chk("max_d2", 32'(bus.out_data), 32'h11);
      tick();
      chk("max_v3", 32'(bus.out_valid), 32'h1);
      chk("max_d3", 32'(bus.out_data), 32'h22);
      chk("max_lat3", 32'(bus.lat_active), 32'h3);
      tick();
      chk("max_v4", 32'(bus.out_valid), 32'h1);
      chk("max_d4", 32'(bus.out_data), 32'h33);
      tick();
      chk("max_v5", 32'(bus.out_valid), 32'h0);
      chk("max_lat5", 32'(bus.lat_active), 32'h3);

      // typ corner, back-pressure and full pipe
      bus.sel       = 2'd1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h40;
      tick();
      chk("bp_ready0", 32'(bus.in_ready), 32'h1);
      chk("bp_lat", 32'(bus.lat_active), 32'h2);
      bus.in_data = 8'h41;
      tick();
      bus.in_data = 8'h42;
      tick();
      bus.in_data = 8'h43;
      tick();
      chk("bp_full", 32'(bus.in_ready), 32'h0);
      bus.in_data = 8'h44;
      tick();
      tick();
      chk("bp_hold_v", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_d", 32'(bus.out_data), 32'h40);
      chk("bp_still_full", 32'(bus.in_ready), 32'h0);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_d1", 32'(bus.out_data), 32'h41);
      chk("bp_v1", 32'(bus.out_valid), 32'h1);
      chk("bp_ready_after_pop", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_d2", 32'(bus.out_data), 32'h42);
      chk("bp_ready_pushpop", 32'(bus.in_ready), 32'h1);
      tick();
      chk("bp_d3", 32'(bus.out_data), 32'h43);
      chk("bp_v3", 32'(bus.out_valid), 32'h1);
      tick();
      chk("bp_d4", 32'(bus.out_data), 32'h44);
      chk("bp_v4", 32'(bus.out_valid), 32'h1);
      tick();
      chk("bp_empty_v", 32'(bus.out_valid), 32'h0);
      chk("bp_empty_busy", 32'(bus.busy), 32'h0);

      // sel change while busy is deferred until the pipe is idle
      bus.sel       = 2'd0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h77;
      tick();
      bus.in_valid = 1'b0;
      bus.sel      = 2'd2;
      chk("sw_v", 32'(bus.out_valid), 32'h1);
      chk("sw_lat0", 32'(bus.lat_active), 32'h1);
      tick();
      chk("sw_lat_busy", 32'(bus.lat_active), 32'h1);
      bus.out_ready = 1'b1;
      tick();
      chk("sw_lat_drain", 32'(bus.lat_active), 32'h1);
      chk("sw_busy_drain", 32'(bus.busy), 32'h0);
      tick();
      chk("sw_lat_idle", 32'(bus.lat_active), 32'h3);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h99;
      tick();
      bus.in_valid = 1'b0;
      chk("sw_v0", 32'(bus.out_valid), 32'h0);
      tick();
      chk("sw_v1", 32'(bus.out_valid), 32'h0);
      tick();
      chk("sw_v2", 32'(bus.out_valid), 32'h1);
      chk("sw_d2", 32'(bus.out_data), 32'h99);
      tick();
      chk("sw_v3", 32'(bus.out_valid), 32'h0);

      // asynchronous reset mid-countdown discards held items
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hB1;
      tick();
      bus.in_data = 8'hB2;
      tick();
      bus.in_valid = 1'b0;
      chk("ar_busy_pre", 32'(bus.busy), 32'h1);
      chk("ar_v_pre", 32'(bus.out_valid), 32'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_v", 32'(bus.out_valid), 32'h0);
      chk("ar_busy", 32'(bus.busy), 32'h0);
      chk("ar_lat", 32'(bus.lat_active), 32'h2);
      chk("ar_ready", 32'(bus.in_ready), 32'h1);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("ar_no_ghost", 32'(bus.out_valid), 32'h0);
      end
      chk("ar_busy_after", 32'(bus.busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
